leb128_stream_decoder: RTL and testbench

//  Byte-serial LEB128 front end. Accepts one encoded byte per cycle on a valid/ready stream.

---
 rtl/leb128_stream_decoder.sv | 228 ++++++++++++++++++++++
 tb/tb_leb128_stream_decoder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leb128_stream_decoder.sv
// ---------------------------------------------------------------------------
// leb128_stream_decoder
//   Byte-serial LEB128 front end between the byte fetch unit and the operand
//   consumer. Encoded bytes arrive one per cycle on a valid/ready stream and
//   are gathered into a 10-byte window. The window is decoded combinationally
//   (ULEB128 or SLEB128, selected per value) and the result is registered
//   onto a valid/ready output together with the byte count and an error flag.
//
//   Optional feature macro: LEB128_OVERLONG_ERR_EN
//     defined   : a 10th byte that still carries a continuation bit marks the
//                 value as overlong; the remaining continuation bytes are
//                 drained and the value is reported as data=0, len=10, err=1.
//     undefined : the 10th byte always terminates the value, m_err is 0.
// ---------------------------------------------------------------------------
module leb128_stream_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        signed_mode,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [63:0] m_data,
    output logic [3:0]  m_len,
    output logic        m_err,
    output logic        m_valid,
    input  logic        m_ready
);

    localparam int         WIN_BYTES = 10;
    localparam logic [3:0] LAST_IDX  = 4'd9;
    localparam logic [3:0] MAX_LEN   = 4'd10;

`ifdef LEB128_OVERLONG_ERR_EN
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CAPT    = 2'd1,
        OUT     = 2'd2,
        DRAIN   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CAPT    = 2'd1,
        OUT     = 2'd2
    } state_t;
`endif

    state_t          state;
    state_t          nxt_state;
    logic [3:0]      cnt;
    logic [9:0][7:0] window;
    logic            mode_q;
    logic            accept;
    logic [3:0]      dec_len_w;
    logic [63:0]     dec_data_w;
`ifdef LEB128_OVERLONG_ERR_EN
    logic            err_q;
`endif

    // Length of the encoding held in the window: position of the first byte
    // without a continuation bit, or the full window if every byte continues.
    function automatic logic [3:0] dec_len(input logic [9:0][7:0] w);
        logic [3:0] len;
        len = MAX_LEN;
        for (int i = WIN_BYTES - 1; i >= 0; i--) begin
            if (!w[i][7]) begin
                len = 4'(i + 1);
            end
        end
        return len;
    endfunction

    // Concatenate the 7-bit payload groups little-endian. Bytes beyond the
    // terminator are zero, so the unsigned result needs no masking. For the
    // signed form the payload is left-justified in the 70-bit accumulator
    // and arithmetically shifted back, replicating bit 7*len-1 upwards.
    function automatic logic [63:0] dec_value(input logic [9:0][7:0] w,
                                              input logic [3:0]      len,
                                              input logic            sgn);
        logic        [69:0] acc;
        logic signed [69:0] sext;
        int unsigned        pad;
        acc = '0;
        for (int i = 0; i < WIN_BYTES; i++) begin
            acc[7*i +: 7] = w[i][6:0];
        end
        pad  = 32'd70 - (32'd7 * 32'(len));
        sext = $signed(acc << pad) >>> pad;
        return sgn ? sext[63:0] : acc[63:0];
    endfunction

    assign dec_len_w  = dec_len(window);
    assign dec_data_w = dec_value(window, dec_len_w, mode_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= nxt_state;
        end
    end

    // Next-state selection and input-side ready; flush overrides everything
    always_comb begin
        nxt_state = state;
        s_ready   = 1'b0;
        case (state)
            COLLECT: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (!s_data[7]) begin
                        nxt_state = CAPT;
                    end else if (cnt == LAST_IDX) begin
`ifdef LEB128_OVERLONG_ERR_EN
                        nxt_state = DRAIN;
`else
                        nxt_state = CAPT;
`endif
                    end
                end
            end
`ifdef LEB128_OVERLONG_ERR_EN
            DRAIN: begin
                s_ready = 1'b1;
                if (s_valid && !s_data[7]) begin
                    nxt_state = CAPT;
                end
            end
`endif
            CAPT: begin
                nxt_state = OUT;
            end
            OUT: begin
                if (m_valid && m_ready) begin
                    nxt_state = COLLECT;
                end
            end
            default: begin
                nxt_state = COLLECT;
            end
        endcase
        if (flush) begin
            nxt_state = COLLECT;
            s_ready   = 1'b0;
        end
    end

    assign accept = s_valid & s_ready;

    // Byte window, byte counter and per-value mode capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            window <= '0;
            mode_q <= 1'b0;
        end else if (flush) begin
            cnt    <= '0;
            window <= '0;
        end else if (state == COLLECT && accept) begin
            window[cnt] <= s_data;
            if (cnt == 4'd0) begin
                mode_q <= signed_mode;
            end
            if (s_data[7] && cnt != LAST_IDX) begin
                cnt <= cnt + 4'd1;
            end
        end else if (state == OUT && m_valid && m_ready) begin
            cnt    <= '0;
            window <= '0;
        end
    end

`ifdef LEB128_OVERLONG_ERR_EN
    // Overlong flag: set when the last window slot still continues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (flush) begin
            err_q <= 1'b0;
        end else if (state == COLLECT && accept && s_data[7] && cnt == LAST_IDX) begin
            err_q <= 1'b1;
        end else if (state == OUT && m_valid && m_ready) begin
            err_q <= 1'b0;
        end
    end

    // Result register; an overlong value reports zero data and full length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_len   <= '0;
            m_err   <= 1'b0;
            m_valid <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (state == CAPT) begin
            m_data  <= err_q ? 64'd0 : dec_data_w;
            m_len   <= err_q ? MAX_LEN : dec_len_w;
            m_err   <= err_q;
            m_valid <= 1'b1;
        end else if (state == OUT && m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end
`else
    assign m_err = 1'b0;

    // Result register: load the decoded window, hold until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_len   <= '0;
            m_valid <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (state == CAPT) begin
            m_data  <= dec_data_w;
            m_len   <= dec_len_w;
            m_valid <= 1'b1;
        end else if (state == OUT && m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_leb128_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_leb128_stream_decoder
//   Drives queued LEB128 encodings into the decoder with optional input gaps,
//   output backpressure and flushes, and compares every delivered result with
//   an arithmetic reference model (or literal values for the directed cases).
//   Honours LEB128_OVERLONG_ERR_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_leb128_stream_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        signed_mode;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] m_data;
    logic [3:0]  m_len;
    logic        m_err;
    logic        m_valid;
    logic        m_ready;

    always #5 clk = ~clk;

    leb128_stream_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .signed_mode (signed_mode),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_len       (m_len),
        .m_err       (m_err),
        .m_valid     (m_valid),
        .m_ready     (m_ready)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       first;
        logic       last;
        logic       mode;
        logic       fl;
    } byte_t;

    typedef struct packed {
        logic [63:0] d;
        logic [3:0]  l;
        logic        e;
    } exp_t;

    byte_t       tx_q[$];
    exp_t        exp_q[$];
    logic [7:0]  ib[16];

    int          tests    = 0;
    int          fails    = 0;
    int          cyc      = 0;
    int          term_cyc = -100;
    int          hs_cyc   = -100;
    int          gap_pct  = 0;
    int          mr_mode  = 0;
    int          hold_n   = 5;
    int          hcnt     = 0;
    logic        prev_mv  = 1'b0;
    logic        prev_mr  = 1'b1;
    logic        prev_fl  = 1'b0;
    logic [63:0] prev_d   = '0;
    logic [3:0]  prev_l   = '0;
    logic        prev_e   = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference: value = sum of payload groups * 128^i, minus 2^(7n) when the
    // top payload bit of a short signed encoding is set; overlong -> 0/10/err.
    function automatic void model(input int n, input logic mode,
                                  output logic [63:0] d, output logic [3:0] l, output logic e);
        logic [127:0] acc;
        if (n > 10) begin
            d = '0;
            l = 4'd10;
            e = 1'b1;
            return;
        end
        acc = '0;
        for (int i = 0; i < n; i++) begin
            acc = acc + (128'(ib[i] & 8'h7f) << (7 * i));
        end
        if (mode && (7 * n < 64) && ib[n-1][6]) begin
            acc = acc - (128'd1 << (7 * n));
        end
        d = acc[63:0];
        l = 4'(n);
        e = 1'b0;
    endfunction

    task automatic push_byte(input logic [7:0] b, input logic first, input logic last,
                             input logic mode, input logic fl);
        byte_t x;
        x.b = b; x.first = first; x.last = last; x.mode = mode; x.fl = fl;
        tx_q.push_back(x);
    endtask

    task automatic add_item(input int n, input logic mode, input logic [63:0] d,
                            input logic [3:0] l, input logic e);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            push_byte(ib[i], i == 0, i == n - 1, mode, 1'b0);
        end
        x.d = d; x.l = l; x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic gen_random();
        int          n;
        int          kind;
        logic        mode;
        logic [6:0]  pay;
        logic [63:0] d;
        logic [3:0]  l;
        logic        e;
        kind = $urandom_range(0, 7);
        mode = 1'($urandom_range(0, 1));
        if (kind == 0) begin
`ifdef LEB128_OVERLONG_ERR_EN
            n = 11 + $urandom_range(0, 3);
            for (int i = 0; i < n - 1; i++) ib[i] = 8'h80 | 8'($urandom_range(0, 127));
            ib[n-1] = 8'($urandom_range(0, 127));
`else
            n = 10;
            for (int i = 0; i < n; i++) ib[i] = 8'h80 | 8'($urandom_range(0, 127));
`endif
        end else begin
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       pay = 7'h7f;
                    1:       pay = 7'h00;
                    default: pay = 7'($urandom_range(0, 127));
                endcase
                ib[i] = {(i < n - 1) ? 1'b1 : 1'b0, pay};
            end
`ifndef LEB128_OVERLONG_ERR_EN
            if (n == 10) ib[9][7] = 1'($urandom_range(0, 1));
`endif
        end
        model(n, mode, d, l, e);
        add_item(n, mode, d, l, e);
    endtask

    // One clock cycle: check held outputs, drive inputs, account handshakes.
    task automatic step();
        logic  sv;
        logic  fl;
        logic  mr;
        byte_t x;
        if (prev_mv && !prev_mr && !prev_fl)
            check("hold", {m_valid, m_err, m_len, m_data}, {1'b1, prev_e, prev_l, prev_d});
        if (m_valid && !prev_mv)
            check("latency", cyc - term_cyc, 2);
        sv = 1'b0;
        fl = 1'b0;
        x  = '0;
        if (tx_q.size() != 0) begin
            x = tx_q[0];
            if (x.fl) begin
                sv = 1'b1;
                fl = 1'b1;
            end else if (gap_pct == 0 || $urandom_range(0, 99) >= gap_pct) begin
                sv = 1'b1;
            end
        end
        case (mr_mode)
            0: mr = 1'b1;
            1: mr = 1'($urandom_range(0, 1));
            2: begin
                mr = 1'b1;
                if (m_valid) begin
                    mr = (hcnt >= hold_n);
                    hcnt++;
                end
            end
            default: mr = 1'b0;
        endcase
        flush       = fl;
        s_valid     = sv;
        s_data      = sv ? x.b : 8'($urandom);
        signed_mode = (sv && x.first) ? x.mode : 1'($urandom);
        m_ready     = mr;
        #1;
        if (fl)                   check("flush_sready", s_ready, 0);
        else if (m_valid)         check("out_sready", s_ready, 0);
        else if (cyc == hs_cyc + 1) check("resume_sready", s_ready, 1);
        if (sv && (fl || s_ready)) begin
            if (!fl && x.last) term_cyc = cyc;
            void'(tx_q.pop_front());
        end
        if (m_valid && mr) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", m_valid, 0);
            end else begin
                if (!fl) begin
                    check("data", m_data, exp_q[0].d);
                    check("len", m_len, exp_q[0].l);
                    check("err", m_err, exp_q[0].e);
                    hs_cyc = cyc;
                end
                void'(exp_q.pop_front());
            end
            hcnt = 0;
        end
        prev_mv = m_valid;
        prev_mr = mr;
        prev_fl = fl;
        prev_d  = m_data;
        prev_l  = m_len;
        prev_e  = m_err;
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int max_cyc, input logic stop_on_valid);
        logic done;
        int   n;
        n    = 0;
        done = 1'b0;
        while (!done && n < max_cyc) begin
            if (stop_on_valid) done = m_valid;
            else done = (tx_q.size() == 0) && (exp_q.size() == 0) && !m_valid;
            if (!done) begin
                step();
                n++;
            end
        end
        check("run_done", done, 1);
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        signed_mode = 1'b0;
        s_data      = 8'h00;
        s_valid     = 1'b0;
        m_ready     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_len", m_len, 0);
        check("rst_m_err", m_err, 0);
        check("rst_s_ready", s_ready, 1);
        rst_n = 1'b1;

        // Worked examples, back to back with no gaps
        gap_pct = 0;
        mr_mode = 0;
        ib[0] = 8'hE5; ib[1] = 8'h8E; ib[2] = 8'h26;
        add_item(3, 1'b0, 64'h0000_0000_0009_8765, 4'd3, 1'b0);
        ib[0] = 8'hC0; ib[1] = 8'hBB; ib[2] = 8'h78;
        add_item(3, 1'b1, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            ib[0] = 8'h7F;
            if (k % 2 == 0) add_item(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 1'b0);
            else            add_item(1, 1'b0, 64'h0000_0000_0000_007F, 4'd1, 1'b0);
        end
        run(200, 1'b0);

        // Output backpressure: five stalled cycles per result
        mr_mode = 2;
        hold_n  = 5;
        ib[0] = 8'hE5; ib[1] = 8'h8E; ib[2] = 8'h26;
        add_item(3, 1'b0, 64'h0000_0000_0009_8765, 4'd3, 1'b0);
        ib[0] = 8'h7F;
        add_item(1, 1'b0, 64'h0000_0000_0000_007F, 4'd1, 1'b0);
        run(200, 1'b0);
        mr_mode = 0;

        // Overlong: ten 0x80 bytes followed by 0x01
        for (int i = 0; i < 10; i++) ib[i] = 8'h80;
`ifdef LEB128_OVERLONG_ERR_EN
        ib[10] = 8'h01;
        add_item(11, 1'b0, 64'd0, 4'd10, 1'b1);
`else
        add_item(10, 1'b0, 64'd0, 4'd10, 1'b0);
        ib[0] = 8'h01;
        add_item(1, 1'b0, 64'd1, 4'd1, 1'b0);
`endif
        run(200, 1'b0);

        // Flush after two bytes of E5 8E 26, then 05
        push_byte(8'hE5, 1'b1, 1'b0, 1'b0, 1'b0);
        push_byte(8'h8E, 1'b0, 1'b0, 1'b0, 1'b0);
        push_byte(8'h26, 1'b0, 1'b0, 1'b0, 1'b1);
        ib[0] = 8'h05;
        add_item(1, 1'b0, 64'd5, 4'd1, 1'b0);
        run(200, 1'b0);

        // Randomized traffic with input gaps and random output ready
        mr_mode = 1;
        gap_pct = 30;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 40; k++) gen_random();
            run(4000, 1'b0);
        end
        gap_pct = 0;

        // Asynchronous reset while a result is waiting
        mr_mode = 3;
        ib[0] = 8'hC0; ib[1] = 8'hBB; ib[2] = 8'h78;
        add_item(3, 1'b1, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 1'b0);
        run(50, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", m_valid, 0);
        check("rst_async_fields", {m_err, m_len, m_data}, 0);
        tx_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n   = 1'b1;
        prev_mv = 1'b0;
        prev_mr = 1'b1;
        prev_fl = 1'b0;
        hcnt    = 0;
        mr_mode = 0;

        // Recovery after reset
        ib[0] = 8'hE5; ib[1] = 8'h8E; ib[2] = 8'h26;
        add_item(3, 1'b0, 64'h0000_0000_0009_8765, 4'd3, 1'b0);
        run(200, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
